// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: opcode tags, buffered entry, FSM states.
package alu_pkg;

    localparam int XLEN = 32;
    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_SLL = 3'b101;
    localparam logic [OP_W-1:0] OP_SRL = 3'b110;
    localparam logic [OP_W-1:0] OP_SLT = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            carry;
        logic            overflow;
        logic            zero;
        logic            negative;
        logic            is_slt;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    function automatic entry_t make_entry(
        input logic [XLEN-1:0] result,
        input logic            carry,
        input logic            overflow,
        input logic            zero,
        input logic            negative,
        input logic            is_slt
    );
        entry_t e;
        e.result   = result;
        e.carry    = carry;
        e.overflow = overflow;
        e.zero     = zero;
        e.negative = negative;
        e.is_slt   = is_slt;
        return e;
    endfunction

endpackage

// File: rtl/alu_result_stage_flag_gen.sv
// Combinational zero/negative/slt flag derivation for a captured ALU result.
module alu_flag_gen #(
    parameter int                WIDTH  = alu_pkg::XLEN,
    parameter int                OP_W   = alu_pkg::OP_W,
    parameter logic [OP_W-1:0]   OP_SLT = alu_pkg::OP_SLT
) (
    input  logic [WIDTH-1:0] result,
    input  logic [OP_W-1:0]  op,
    output logic             zero,
    output logic             negative,
    output logic             is_slt
);

    assign zero     = ~|result;
    assign negative = result[WIDTH-1];
    assign is_slt   = (op == OP_SLT);

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage with 2-entry skid buffer and flush.
// Optional sticky overflow flag enabled by ALU_RESULT_STICKY_OVF_EN.
module alu_result_stage #(
    parameter int              WIDTH  = alu_pkg::XLEN,
    parameter int              OP_W   = alu_pkg::OP_W,
    parameter logic [OP_W-1:0] OP_SLT = alu_pkg::OP_SLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    input  logic             in_overflow,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_negative,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_is_slt,
    input  logic             clr_sticky,
    output logic             sticky_ovf
);
    import alu_pkg::*;

    state_e state_q, state_n;
    entry_t main_q, main_n;
    entry_t skid_q, skid_n;
    entry_t cap;
    logic   ready_q, ready_n;
    logic   acc, xfer;
    logic   f_zero, f_neg, f_slt;

    alu_flag_gen #(
        .WIDTH  (WIDTH),
        .OP_W   (OP_W),
        .OP_SLT (OP_SLT)
    ) u_flags (
        .result   (in_result),
        .op       (in_op),
        .zero     (f_zero),
        .negative (f_neg),
        .is_slt   (f_slt)
    );

    assign cap  = make_entry(in_result, in_carry, in_overflow,
                             f_zero, f_neg, f_slt);
    assign acc  = in_valid & ready_q;
    assign xfer = (state_q != EMPTY) & out_ready;

    always_comb begin
        state_n = state_q;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_n = ONE;
                        main_n  = cap;
                    end
                end
                ONE: begin
                    if (acc && xfer) begin
                        main_n = cap;
                    end else if (acc) begin
                        state_n = TWO;
                        skid_n  = cap;
                    end else if (xfer) begin
                        state_n = EMPTY;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        state_n = ONE;
                        main_n  = skid_q;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
        ready_n = (state_n != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_n;
            main_q  <= main_n;
            skid_q  <= skid_n;
            ready_q <= ready_n;
        end
    end

    assign in_ready     = ready_q;
    assign out_valid    = (state_q != EMPTY);
    assign out_result   = main_q.result;
    assign out_zero     = main_q.zero;
    assign out_negative = main_q.negative;
    assign out_carry    = main_q.carry;
    assign out_overflow = main_q.overflow;
    assign out_is_slt   = main_q.is_slt;

`ifdef ALU_RESULT_STICKY_OVF_EN
    logic sticky_q;

    // a set from a same-cycle overflow transfer beats the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (xfer && main_q.overflow) begin
            sticky_q <= 1'b1;
        end else if (clr_sticky) begin
            sticky_q <= 1'b0;
        end
    end

    assign sticky_ovf = sticky_q;
`else
    logic unused_clr;

    assign unused_clr = clr_sticky;
    assign sticky_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized bench for alu_result_stage against a queue-based model.
module tb_alu_result_stage;

    localparam logic [2:0] SLT = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_carry;
    logic        in_overflow;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_negative;
    logic        out_carry;
    logic        out_overflow;
    logic        out_is_slt;
    logic        clr_sticky;
    logic        sticky_ovf;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        o;
        logic [2:0]  op;
    } ment_t;

    ment_t q[$];
    bit    m_sticky;
    int    tests = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_carry     (in_carry),
        .in_overflow  (in_overflow),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_negative (out_negative),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_is_slt   (out_is_slt),
        .clr_sticky   (clr_sticky),
        .sticky_ovf   (sticky_ovf)
    );

    // Drive one cycle of inputs and advance the model; no checking here.
    task automatic step(input logic v, input logic [31:0] r,
                        input logic c, input logic o, input logic [2:0] op,
                        input logic rdy, input logic fl, input logic clr);
        bit    acc;
        bit    xf;
        ment_t e;
        in_valid    = v;
        in_result   = r;
        in_carry    = c;
        in_overflow = o;
        in_op       = op;
        out_ready   = rdy;
        flush       = fl;
        clr_sticky  = clr;
        acc = v && (q.size() < 2);
        xf  = (q.size() > 0) && rdy;
        @(posedge clk);
`ifdef ALU_RESULT_STICKY_OVF_EN
        if (xf && q[0].o) m_sticky = 1'b1;
        else if (clr) m_sticky = 1'b0;
`endif
        if (fl) begin
            q.delete();
        end else begin
            if (xf) void'(q.pop_front());
            if (acc) begin
                e.r = r; e.c = c; e.o = o; e.op = op;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, rdy, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        in_valid = 0; in_result = 0; in_carry = 0; in_overflow = 0;
        in_op = 0; out_ready = 0; flush = 0; clr_sticky = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_hs got v=%b r=%b exp v=0 r=1",
                     out_valid, in_ready);
        end
        tests++;
        if ({out_result, out_zero, out_negative, out_carry, out_overflow,
             out_is_slt, sticky_ovf} !== 38'h0) begin
            fails++;
            $display("FAIL reset_data got res=%h flags=%b%b%b%b%b s=%b exp 0",
                     out_result, out_zero, out_negative, out_carry,
                     out_overflow, out_is_slt, sticky_ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_sticky = 1'b0;
    endtask

    task automatic test_single;
        step(1'b1, 32'h1, 1'b0, 1'b0, SLT, 1'b1, 1'b0, 1'b0);
        tests++;
        if (out_valid !== 1'b1 || out_result !== 32'h1 ||
            out_is_slt !== 1'b1 || out_zero !== 1'b0) begin
            fails++;
            $display("FAIL single got v=%b res=%h slt=%b z=%b exp v=1 res=1 slt=1 z=0",
                     out_valid, out_result, out_is_slt, out_zero);
        end
        idle(1'b1);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_drain got v=%b exp 0", out_valid);
        end
    endtask

    task automatic test_flags;
        step(1'b1, 32'h80000002, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0);
        tests++;
        if (out_negative !== 1'b1 || out_overflow !== 1'b1 ||
            out_zero !== 1'b0 || out_is_slt !== 1'b0) begin
            fails++;
            $display("FAIL flags_neg got n=%b o=%b z=%b s=%b exp n=1 o=1 z=0 s=0",
                     out_negative, out_overflow, out_zero, out_is_slt);
        end
        step(1'b1, 32'h0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0);
        tests++;
        if (out_zero !== 1'b1 || out_negative !== 1'b0 ||
            out_carry !== 1'b1 || out_overflow !== 1'b0) begin
            fails++;
            $display("FAIL flags_zero got z=%b n=%b c=%b o=%b exp z=1 n=0 c=1 o=0",
                     out_zero, out_negative, out_carry, out_overflow);
        end
        idle(1'b1);
    endtask

    task automatic test_backpressure;
        step(1'b1, 32'h75, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h49, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h75) begin
            fails++;
            $display("FAIL bp_full got rdy=%b v=%b res=%h exp rdy=0 v=1 res=75",
                     in_ready, out_valid, out_result);
        end
        idle(1'b0);
        tests++;
        if (out_result !== 32'h75 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold got res=%h rdy=%b exp res=75 rdy=0",
                     out_result, in_ready);
        end
        idle(1'b1);
        tests++;
        if (out_valid !== 1'b1 || out_result !== 32'h49 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_second got v=%b res=%h rdy=%b exp v=1 res=49 rdy=1",
                     out_valid, out_result, in_ready);
        end
        idle(1'b1);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain got v=%b exp 0", out_valid);
        end
    endtask

    task automatic test_stream;
        logic [31:0] vals[8];
        foreach (vals[i]) vals[i] = $urandom;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, vals[i], 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0);
            tests++;
            if (out_valid !== 1'b1 || out_result !== vals[i] || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL stream[%0d] got v=%b res=%h rdy=%b exp v=1 res=%h rdy=1",
                         i, out_valid, out_result, in_ready, vals[i]);
            end
        end
        idle(1'b1);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stream_end got v=%b exp 0", out_valid);
        end
    endtask

    task automatic test_flush;
        step(1'b1, 32'h11, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h4FFFFF27, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_two got v=%b rdy=%b exp v=0 rdy=1",
                     out_valid, in_ready);
        end
        step(1'b1, 32'h33, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h4FFFFF27, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_one got v=%b rdy=%b exp v=0 rdy=1",
                     out_valid, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL flush_leak[%0d] got v=%b res=%h exp v=0",
                         i, out_valid, out_result);
            end
        end
    endtask

    task automatic test_async_reset;
        step(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, SLT, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h12345678, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0 ||
            out_carry !== 1'b0 || out_overflow !== 1'b0 || out_is_slt !== 1'b0 ||
            sticky_ovf !== 1'b0) begin
            fails++;
            $display("FAIL async_rst got v=%b rdy=%b res=%h c=%b o=%b s=%b st=%b exp reset values",
                     out_valid, in_ready, out_result, out_carry, out_overflow,
                     out_is_slt, sticky_ovf);
        end
        q.delete();
        m_sticky = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sticky;
        step(1'b1, 32'h7, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        tests++;
        if (sticky_ovf !== m_sticky) begin
            fails++;
            $display("FAIL sticky_set got %b exp %b", sticky_ovf, m_sticky);
        end
        idle(1'b0);
        tests++;
        if (sticky_ovf !== m_sticky) begin
            fails++;
            $display("FAIL sticky_hold got %b exp %b", sticky_ovf, m_sticky);
        end
        // overflow transfer coinciding with clear
        step(1'b1, 32'h8, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
        tests++;
        if (sticky_ovf !== m_sticky) begin
            fails++;
            $display("FAIL sticky_setwins got %b exp %b", sticky_ovf, m_sticky);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
        tests++;
        if (sticky_ovf !== m_sticky || sticky_ovf !== 1'b0) begin
            fails++;
            $display("FAIL sticky_clr got %b exp %b", sticky_ovf, m_sticky);
        end
    endtask

    task automatic test_random;
        logic [31:0] r;
        logic [37:0] got;
        logic [37:0] exp;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            step($urandom_range(0, 3) != 0, r, 1'($urandom), 1'($urandom),
                 3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
            tests++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                fails++;
                $display("FAIL rand_hs cyc=%0d got v=%b rdy=%b exp v=%b rdy=%b",
                         cyc, out_valid, in_ready, q.size() > 0, q.size() < 2);
            end
            if (q.size() > 0) begin
                got = {out_result, out_zero, out_negative, out_carry,
                       out_overflow, out_is_slt, 1'b0};
                exp = {q[0].r, q[0].r == 32'h0, q[0].r >= 32'h80000000,
                       q[0].c, q[0].o, q[0].op == SLT, 1'b0};
                tests++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, got, exp);
                end
            end
            tests++;
            if (sticky_ovf !== m_sticky) begin
                fails++;
                $display("FAIL rand_sticky cyc=%0d got=%b exp=%b",
                         cyc, sticky_ovf, m_sticky);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_flags();
        test_backpressure();
        test_stream();
        test_flush();
        test_sticky();
        test_random();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU/SLT datapath.
- Captures each ALU result with its carry/overflow/opcode, derives zero and negative flags, and presents them to the next pipeline stage over a valid/ready handshake.
- A 2-entry skid buffer gives full throughput, with in_ready driven from a register.
- A flush input discards in-flight results on branch redirect.

Parameters:
- WIDTH, 32, datapath width of the ALU result.
- OP_W, 3, width of the ALU opcode tag carried alongside the result.
- OP_SLT, 3'b111, opcode value that marks a set-less-than result.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  discard all buffered entries
- in_valid  input  1  upstream ALU result valid
- in_ready  output  1  stage can accept; registered
- in_result  input  WIDTH  ALU result
- in_carry  input  1  ALU carry-out
- in_overflow  input  1  ALU signed overflow
- in_op  input  OP_W  ALU opcode tag
- out_valid  output  1  output entry valid
- out_ready  input  1  downstream accepts
- out_result  output  WIDTH  buffered result
- out_zero  output  1  result == 0
- out_negative  output  1  result[WIDTH-1]
- out_carry  output  1  buffered carry
- out_overflow  output  1  buffered overflow
- out_is_slt  output  1  entry op == OP_SLT
- clr_sticky  input  1  clear sticky overflow (see Optional Feature)
- sticky_ovf  output  1  sticky overflow flag

Behaviour:
- Reset (async, rst=1): state EMPTY; out_valid=0, in_ready=1, out_result=0; all flags 0; sticky_ovf=0.
- Entry fields: result, carry, overflow, zero, negative, is_slt. Flags are computed from in_result/in_op at capture, not at output.
- Accept: in_valid & in_ready at a rising edge. Transfer: out_valid & out_ready at a rising edge.
- Outputs always reflect the main register; the skid register holds the overflow entry.
- States:
  - EMPTY:
    - accept -> ONE (load main).
  - ONE:
    - accept & transfer -> ONE (load main).
    - accept & no transfer -> TWO (load skid); in_ready falls next cycle.
    - transfer only -> EMPTY.
  - TWO:
    - in_ready=0.
    - transfer -> ONE (skid moves to main).
- Latency: accept to out_valid is 1 cycle. Throughput is 1 per cycle while out_ready=1.
- in_ready = (state != TWO), registered. Never combinationally dependent on out_ready.
- Output stability: while out_valid=1 and out_ready=0, all out_* hold their values.
- Flush (synchronous, highest priority): next state EMPTY, in_ready=1. Any same-cycle accept is dropped. sticky_ovf is unaffected.
- Width rules: zero = ~|result over WIDTH bits. No sign extension; values pass through unmodified.
- rst asserted mid-transfer: entries are lost and outputs go to reset values immediately.

Optional Feature:
- Macro: ALU_RESULT_STICKY_OVF_EN.
- Defined:
  - sticky_ovf sets on the cycle after any transfer whose entry has overflow=1.
  - clr_sticky=1 clears it; if a set and clr_sticky coincide, set wins.
- Not defined:
  - sticky_ovf is constant 0 and clr_sticky is ignored.
  - Port list is identical in both builds.

Decomposition:
- Shared package alu_pkg:
  - OP_W and the ALU opcode constants (including OP_SLT).
  - Entry struct typedef {result, carry, overflow, zero, negative, is_slt}.
  - State enum {EMPTY, ONE, TWO}.
- One sub-module, alu_flag_gen: combinational zero/negative/is_slt derivation from result and op. Used once at the capture input.

Test Plan:
- Single entry: in_result=32'h00000001, in_op=OP_SLT, out_ready=1 -> next cycle out_valid=1, out_result=1, out_is_slt=1, out_zero=0.
- Flags:
  - in_result=32'h80000002, in_overflow=1 -> out_negative=1, out_overflow=1.
  - in_result=32'h0 -> out_zero=1.
- Backpressure:
  - out_ready=0, send 32'h75 then 32'h49 -> in_ready=0 after the second accept; out_result holds 32'h75.
  - out_ready=1 -> 32'h75 then 32'h49 emerge in order, and in_ready returns to 1.
- Streaming: 8 back-to-back entries with out_ready=1 -> 8 transfers in 8 consecutive cycles, in order, none dropped or duplicated.
- Flush: with TWO entries buffered, flush=1 concurrently with in_valid=1 (32'h4FFFFF27) -> next cycle out_valid=0, in_ready=1, and 32'h4FFFFF27 is never output.
- Reset/sticky:
  - rst pulse mid-stream -> outputs go to 0 asynchronously.
  - With ALU_RESULT_STICKY_OVF_EN, transferring an overflow entry -> sticky_ovf=1 until clr_sticky.
  - Without the macro -> sticky_ovf stays 0.
